// File: rtl/strip3_conv_engine.sv
// 3x3 valid-mode convolution over a 224x30 strip held in local memory.
// One window per 12 cycles: 9 fetches, a wait, a multiply stage and an accumulate/write stage.
module strip3_conv_engine (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        kernel_valid_i,
  input  logic [8:0]  kernel_0_i,
  input  logic [8:0]  kernel_1_i,
  input  logic [8:0]  kernel_2_i,
  input  logic [8:0]  kernel_3_i,
  input  logic [8:0]  kernel_4_i,
  input  logic [8:0]  kernel_5_i,
  input  logic [8:0]  kernel_6_i,
  input  logic [8:0]  kernel_7_i,
  input  logic [8:0]  kernel_8_i,
  input  logic        in_we_i,
  input  logic [12:0] in_addr_i,
  input  logic [8:0]  in_data_i,
  input  logic [12:0] rd_addr_i,
  output logic [22:0] rd_data_o,
  output logic        done_o
);

  localparam int unsigned KSize    = 3;
  localparam int unsigned ImgW     = 224;
  localparam int unsigned ImgH     = 30;
  localparam int unsigned OutW     = ImgW - KSize + 1;
  localparam int unsigned OutH     = ImgH - KSize + 1;
  localparam int unsigned InDepth  = ImgW * ImgH;
  localparam int unsigned OutDepth = OutW * OutH;

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StMul, StAcc, StDone} state_e;

  state_e state_q, state_d;
  logic [3:0] tap_q, tap_d;
  logic [7:0] h_q, h_d;
  logic [4:0] v_q, v_d;
  logic       done_q, done_d;
  logic       start_run, mul_en, acc_we;

  logic signed [8:0]  kern_in [9];
  logic signed [8:0]  kern_q  [9];
  logic signed [8:0]  win_q   [9];
  logic signed [17:0] prod_q  [9];
  logic signed [8:0]  in_mem  [InDepth];
  logic signed [22:0] out_mem [OutDepth];
  logic signed [8:0]  mem_rd_q;
  logic signed [22:0] sum;
  logic signed [22:0] rd_data_q;
  logic [1:0]         tap_row, tap_col;
  logic [12:0]        fetch_addr, out_addr;

  assign kern_in[0] = kernel_0_i;
  assign kern_in[1] = kernel_1_i;
  assign kern_in[2] = kernel_2_i;
  assign kern_in[3] = kernel_3_i;
  assign kern_in[4] = kernel_4_i;
  assign kern_in[5] = kernel_5_i;
  assign kern_in[6] = kernel_6_i;
  assign kern_in[7] = kernel_7_i;
  assign kern_in[8] = kernel_8_i;

  always_comb begin
    if (tap_q >= 4'd6) begin
      tap_row = 2'd2;
      tap_col = 2'(tap_q - 4'd6);
    end else if (tap_q >= 4'd3) begin
      tap_row = 2'd1;
      tap_col = 2'(tap_q - 4'd3);
    end else begin
      tap_row = 2'd0;
      tap_col = 2'(tap_q);
    end
  end

  assign fetch_addr = ({8'd0, v_q} + {11'd0, tap_row}) * 13'(ImgW) + {5'd0, h_q} + {11'd0, tap_col};
  assign out_addr   = {8'd0, v_q} * 13'(OutW) + {5'd0, h_q};

  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++) sum = sum + 23'(prod_q[i]);
  end

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    h_d       = h_q;
    v_d       = v_q;
    done_d    = done_q;
    start_run = 1'b0;
    mul_en    = 1'b0;
    acc_we    = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start_i && kernel_valid_i) begin
          state_d   = StFetch;
          start_run = 1'b1;
          done_d    = 1'b0;
          tap_d     = '0;
          h_d       = '0;
          v_d       = '0;
        end
      end
      StFetch: begin
        tap_d = tap_q + 4'd1;
        if (tap_q == 4'(KSize * KSize - 1)) begin
          tap_d   = '0;
          state_d = StWait;
        end
      end
      StWait: state_d = StMul;
      StMul: begin
        mul_en  = 1'b1;
        state_d = StAcc;
      end
      StAcc: begin
        acc_we  = 1'b1;
        state_d = StFetch;
        if (h_q == 8'(OutW - 1)) begin
          h_d = '0;
          if (v_q == 5'(OutH - 1)) begin
            v_d     = '0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            v_d = v_q + 5'd1;
          end
        end else begin
          h_d = h_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Memories are deliberately not reset; a reset mid-run leaves partial results readable.
  always_ff @(posedge clk_i) begin
    if (in_we_i && (state_q == StIdle || state_q == StDone) && in_addr_i < 13'(InDepth)) begin
      in_mem[in_addr_i] <= in_data_i;
    end
    mem_rd_q <= in_mem[fetch_addr];
    if (acc_we) out_mem[out_addr] <= sum;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      tap_q     <= '0;
      h_q       <= '0;
      v_q       <= '0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
      for (int i = 0; i < 9; i++) begin
        kern_q[i] <= '0;
        win_q[i]  <= '0;
        prod_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      h_q     <= h_d;
      v_q     <= v_d;
      done_q  <= done_d;
      if (rd_addr_i < 13'(OutDepth)) rd_data_q <= out_mem[rd_addr_i];
      else                           rd_data_q <= '0;
      // Read data for tap k arrives while tap k+1 is being issued.
      if (state_q == StFetch && tap_q != 4'd0) win_q[tap_q - 4'd1] <= mem_rd_q;
      if (state_q == StWait) win_q[8] <= mem_rd_q;
      for (int i = 0; i < 9; i++) begin
        if (start_run) kern_q[i] <= kern_in[i];
        if (mul_en)    prod_q[i] <= 18'(win_q[i]) * 18'(kern_q[i]);
      end
    end
  end

  assign rd_data_o = rd_data_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_strip3_conv_engine.sv
// Directed bench for strip3_conv_engine: reset, handshake, mid-run reset and one full run.
module tb_strip3_conv_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        kv;
  logic [8:0]  kern [9];
  logic        in_we;
  logic [12:0] in_addr;
  logic [8:0]  in_data;
  logic [12:0] rd_addr;
  logic [22:0] rd_data;
  logic        done;

  int errors = 0;
  int checks = 0;
  int cyc;
  int kb [9] = '{-256, 3, -5, 7, 255, -2, 11, -13, 17};

  always #5 clk = ~clk;

  strip3_conv_engine dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .kernel_valid_i (kv),
    .kernel_0_i     (kern[0]),
    .kernel_1_i     (kern[1]),
    .kernel_2_i     (kern[2]),
    .kernel_3_i     (kern[3]),
    .kernel_4_i     (kern[4]),
    .kernel_5_i     (kern[5]),
    .kernel_6_i     (kern[6]),
    .kernel_7_i     (kern[7]),
    .kernel_8_i     (kern[8]),
    .in_we_i        (in_we),
    .in_addr_i      (in_addr),
    .in_data_i      (in_data),
    .rd_addr_i      (rd_addr),
    .rd_data_o      (rd_data),
    .done_o         (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Columns 0..7 hold -256 and column 223 holds 255 to exercise product/sum extremes.
  function automatic int pix(input int x, input int y);
    if (x < 8) return -256;
    if (x == 223) return 255;
    return ((x + 3 * y) % 256) - 128;
  endfunction

  function automatic int exp_b(input int h, input int v);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += pix(h + j, v + i) * kb[i * 3 + j];
    return s;
  endfunction

  task automatic set_identity();
    for (int i = 0; i < 9; i++) kern[i] = 9'd0;
    kern[4] = 9'd1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; kv = 1'b0; in_we = 1'b0;
    in_addr = '0; in_data = '0; rd_addr = '0;
    for (int i = 0; i < 9; i++) kern[i] = '0;
    repeat (3) tick();
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_rd_data", $signed(rd_data), 0);
    rst_n = 1'b1;
    tick();

    for (int a = 0; a < 6720; a++) begin
      in_we = 1'b1; in_addr = 13'(a); in_data = 9'(pix(a % 224, a / 224));
      tick();
    end
    in_we = 1'b0;

    // start without kernel_valid must not launch a run
    set_identity();
    start = 1'b1; kv = 1'b0;
    repeat (100) tick();
    chk("no_kv_done", {31'd0, done}, 0);
    start = 1'b0;
    tick();

    // Run A (identity kernel), abandoned by reset after 2000 cycles
    kv = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; rd_addr = 13'd0;
    repeat (2000) tick();
    chk("runA_out0", $signed(rd_data), -256);
    rd_addr = 13'd10;
    tick();
    chk("runA_out10", $signed(rd_data), -114);
    chk("runA_busy_done", {31'd0, done}, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_done", {31'd0, done}, 0);
    chk("async_rst_rd_data", $signed(rd_data), 0);
    #2 rst_n = 1'b1;
    tick();
    rd_addr = 13'd0;
    tick();
    chk("partial_kept", $signed(rd_data), -256);
    chk("idle_done", {31'd0, done}, 0);

    // Run B: new kernel; later kernel changes, start and in_we pulses must be ignored
    for (int i = 0; i < 9; i++) kern[i] = 9'(kb[i]);
    kv = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    set_identity();
    cyc = 0;
    while (cyc < 75000 && done !== 1'b1) begin
      tick();
      cyc++;
      in_we = 1'b0; start = 1'b0;
      if (cyc == 2) begin
        in_we = 1'b1; in_addr = 13'd225; in_data = 9'd77;
      end
      if (cyc == 40000) begin
        in_we = 1'b1; in_addr = 13'd6696; in_data = 9'd0;
      end
      if (cyc == 100) start = 1'b1;
    end
    in_we = 1'b0; start = 1'b0;
    chk("done_latency", cyc, 74592);

    rd_addr = 13'd6216;
    tick();
    chk("rd_oob_6216", $signed(rd_data), 0);
    rd_addr = 13'd8191;
    tick();
    chk("rd_oob_8191", $signed(rd_data), 0);
    rd_addr = 13'd0;
    tick();
    chk("out_0_0_hand", $signed(rd_data), -4352);
    for (int h = 0; h < 222; h++) begin
      rd_addr = 13'(h);
      tick();
      chk($sformatf("out_%0d_0", h), $signed(rd_data), exp_b(h, 0));
      rd_addr = 13'(27 * 222 + h);
      tick();
      chk($sformatf("out_%0d_27", h), $signed(rd_data), exp_b(h, 27));
    end
    for (int v = 1; v < 27; v++) begin
      rd_addr = 13'(v * 222);
      tick();
      chk($sformatf("out_0_%0d", v), $signed(rd_data), exp_b(0, v));
      rd_addr = 13'(v * 222 + 221);
      tick();
      chk($sformatf("out_221_%0d", v), $signed(rd_data), exp_b(221, v));
    end
    chk("done_held", {31'd0, done}, 1);

    #2 rst_n = 1'b0;
    #1;
    chk("final_rst_done", {31'd0, done}, 0);
    chk("final_rst_rd_data", $signed(rd_data), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/strip3_conv_engine.md
# strip3_conv_engine

Self-contained 3x3 valid-mode convolution engine for one horizontal image strip (224 x 30 pixels, 9-bit signed). It holds the strip in a local input memory and slides a latched 3x3 kernel across it in raster order. Each window is computed with nine parallel signed multipliers and an adder tree, and the 222 x 28 results are written into a local output memory. It sits beside the sibling strip units and is read back through a random-access port once `done` rises.

## Interface
Parameters (fixed values; implementation need not support others):
- `KSIZE` 3: kernel side.
- `IMG_W` 224: strip width in pixels.
- `IMG_H` 30: strip height in pixels.
- `OUT_W` = IMG_W-KSIZE+1 = 222; `OUT_H` = IMG_H-KSIZE+1 = 28.

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: level; begins a run when sampled with `kernel_valid` high in IDLE or DONE.
- `kernel_valid` in 1: kernel inputs are stable and valid.
- `kernel_0`..`kernel_8` in 9 signed each: kernel taps, row-major (k0 top-left, k4 centre, k8 bottom-right).
- `in_we` in 1: input memory write enable.
- `in_addr` in 13: input memory write address, pixel (x,y) at y*224+x, valid range 0..6719.
- `in_data` in 9 signed: pixel to write.
- `rd_addr` in 13: output memory read address, result (h,v) at v*222+h, valid range 0..6215.
- `rd_data` out 23 signed: registered read data.
- `done` out 1: run complete; held until next run or reset.

## Operation
- States: IDLE, FETCH, WAIT, MUL, ACC, DONE.
- **IDLE / DONE.** On `start && kernel_valid`:
  - latch all nine kernel taps into internal registers;
  - clear `done` and the window counters (v=0, h=0);
  - go to FETCH.
  - Otherwise stay in the current state.
- **FETCH (9 cycles, k=0..8).** Issue input-memory read at (v+k/3)*224 + h + k%3. The memory has 1-cycle latency; the pixel returned for tap k is captured into window register k on the following cycle.
- **WAIT (1 cycle).** Capture tap 8.
- **MUL (1 cycle).** Multiplier clock-enable is high. Register the nine products window[k]*kernel_k as full-precision 18-bit signed values.
- **ACC (1 cycle).**
  - Sum the nine products, sign-extended, into a 23-bit signed value with no saturation; the maximum magnitude 589824 fits.
  - Write the sum to output memory address v*222+h.
  - Advance h; when h wraps from 221 to 0, advance v.
  - After window (221,27), go to DONE; otherwise return to FETCH.
- **DONE.** `done`=1.
- **Input memory load.**
  - A write with `in_we`=1 is honoured only in IDLE or DONE; it is ignored in FETCH/WAIT/MUL/ACC.
  - Addresses above 6719 are ignored.
- **Read port.** Always active in every state. `rd_data` = out_mem[rd_addr], registered. Addresses above 6215 return 0.
- **Kernel stability.** Kernel inputs changing mid-run have no effect.
- **`start` while busy.** Ignored.
- **Reset.**
  - Forces IDLE, `done`=0, counters, window and product registers to 0, `rd_data`=0.
  - Memory contents are not cleared.
  - Reset mid-run abandons the run; partially written results remain in memory.

## Timing
- Per output: exactly 12 cycles (FETCH 9, WAIT 1, MUL 1, ACC 1). No overlap between windows.
- Run latency: `done` rises 6216*12 = 74592 cycles after the first FETCH cycle. The first FETCH cycle is the cycle after `start` is accepted.
- Output write for window n occurs in cycle 12n+11 relative to the first FETCH cycle (n = v*222+h).
- Input writes take effect at the clock edge. A read of the same address in the next cycle returns new data.
- `rd_data` is valid 1 cycle after `rd_addr` is presented.
- Reset value of all outputs: `done`=0, `rd_data`=0.

## Test plan
- **Reset:** assert `reset_n`=0 asynchronously mid-cycle -> `done`=0 and `rd_data`=0 immediately; FSM in IDLE after release.
- **Uniform:**
  - Stimulus: load all pixels = 1, kernel all 1, pulse `start` with `kernel_valid`.
  - `done` rises exactly 74592 cycles after the first FETCH.
  - Every rd_addr 0..6215 returns 9.
- **Identity/addressing:**
  - Stimulus: pixel(x,y) = (x+3y) mod 256 - 128, kernel k4=1 and others 0.
  - out(h,v) = pixel(h+1,v+1). Check (0,0), (221,0), (0,27), (221,27).
- **Extremes:**
  - All pixels -256, all taps -256 -> every result 589824.
  - All pixels 255, all taps -256 -> every result -587520.
- **Handshake:**
  - `start`=1 with `kernel_valid`=0 for 100 cycles -> `done` stays 0 and the memory is unchanged.
  - `start` pulsed during a run -> ignored; completion time unchanged.
  - `in_we` pulses during a run -> ignored; results match pre-run image.
- **Reset mid-run:**
  - Stimulus: reset at cycle 5000 of a run, then restart with a new kernel.
  - `done` rises 74592 cycles after the new FETCH.
  - Results reflect the new kernel.
